// File: rtl/reclaim.sv
// Commit-side release stage: tracks the committed logical-to-physical map (RRAT)
// and returns registers made obsolete by each commit to map's free list via a small FIFO.
module reclaim #(
    parameter int LOG_RF_DEPTH   = 8,
    parameter int PHY_RF_DEPTH   = 16,
    parameter int REL_FIFO_DEPTH = 4,
    localparam int LW = $clog2(LOG_RF_DEPTH),
    localparam int PW = $clog2(PHY_RF_DEPTH),
    localparam int AW = $clog2(REL_FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          commit_valid,
    input  logic [LW-1:0] commit_rd,
    input  logic [PW-1:0] commit_pd,
    output logic          commit_ready,
    output logic          free_valid,
    output logic [PW-1:0] free_pd,
    input  logic          free_ready,
    input  logic [LW-1:0] rrat_rd_addr,
    output logic [PW-1:0] rrat_rd_data,
    output logic [CW-1:0] rel_count
);

    logic [PW-1:0] rrat_q [LOG_RF_DEPTH];
    logic [PW-1:0] mem_q  [REL_FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    logic          acc;
    logic          push;
    logic          pop;
    logic [PW-1:0] old_pd;

    // Ready looks only at registered occupancy so there is no path from free_ready.
    assign commit_ready = en && !rst && (count_q < CW'(REL_FIFO_DEPTH));
    assign free_valid   = (count_q != '0);
    assign free_pd      = free_valid ? mem_q[rd_q] : '0;
    assign rel_count    = count_q;
    assign rrat_rd_data = rrat_q[rrat_rd_addr];

    always_comb begin
        acc     = commit_valid && commit_ready;
        old_pd  = rrat_q[commit_rd];
        push    = acc && (old_pd != commit_pd);
        pop     = free_valid && free_ready;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOG_RF_DEPTH; i++) begin
                rrat_q[i] <= PW'(i);
            end
            for (int i = 0; i < REL_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (acc) begin
                rrat_q[commit_rd] <= commit_pd;
            end
            if (push) begin
                mem_q[wr_q] <= old_pd;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reclaim.sv
// Testbench for reclaim: directed scenarios plus randomized traffic checked
// against an array-and-queue model of the committed map and release order.
module tb_reclaim;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       commit_valid;
    logic [2:0] commit_rd;
    logic [3:0] commit_pd;
    logic       commit_ready;
    logic       free_valid;
    logic [3:0] free_pd;
    logic       free_ready;
    logic [2:0] rrat_rd_addr;
    logic [3:0] rrat_rd_data;
    logic [2:0] rel_count;

    int tests_run = 0;
    int failed    = 0;

    int rrat_m [8];
    int q_m [$];

    reclaim dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .commit_valid(commit_valid),
        .commit_rd   (commit_rd),
        .commit_pd   (commit_pd),
        .commit_ready(commit_ready),
        .free_valid  (free_valid),
        .free_pd     (free_pd),
        .free_ready  (free_ready),
        .rrat_rd_addr(rrat_rd_addr),
        .rrat_rd_data(rrat_rd_data),
        .rel_count   (rel_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rrat_m[i] = i;
        q_m.delete();
    endtask

    // Advance one clock; the model applies the same cycle's rules from the inputs
    // as driven before the edge. Returns mid-cycle (negedge).
    task automatic step();
        bit acc_m;
        bit pop_m;
        int old;
        acc_m = commit_valid && en && !rst && (q_m.size() < 4);
        pop_m = (q_m.size() != 0) && free_ready;
        @(posedge clk);
        if (!rst) begin
            old = rrat_m[commit_rd];
            if (pop_m) void'(q_m.pop_front());
            if (acc_m) begin
                if (old != int'(commit_pd)) q_m.push_back(old);
                rrat_m[commit_rd] = int'(commit_pd);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; commit_valid = 1'b0; commit_rd = '0; commit_pd = '0;
        free_ready = 1'b0; rrat_rd_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0; en = 1'b1; rrat_rd_addr = 3'd3;
        #1;
        tests_run++;
        if (rrat_rd_data !== 4'd3) begin failed++; $display("FAIL reset_rrat3: got %0d expected 3", rrat_rd_data); end
        tests_run++;
        if (free_valid !== 1'b0) begin failed++; $display("FAIL reset_free_valid: got %0b expected 0", free_valid); end
        tests_run++;
        if (rel_count !== 3'd0) begin failed++; $display("FAIL reset_rel_count: got %0d expected 0", rel_count); end
        tests_run++;
        if (commit_ready !== 1'b1) begin failed++; $display("FAIL reset_commit_ready: got %0b expected 1", commit_ready); end
    endtask

    task automatic test_chain();
        free_ready = 1'b1;
        commit_valid = 1'b1; commit_rd = 3'd1; commit_pd = 4'd8;
        step();
        commit_rd = 3'd1; commit_pd = 4'd9; rrat_rd_addr = 3'd1;
        #1;
        tests_run++;
        if (free_valid !== 1'b1 || free_pd !== 4'd1) begin failed++; $display("FAIL chain_first_free: got v=%0b pd=%0d expected v=1 pd=1", free_valid, free_pd); end
        tests_run++;
        if (rrat_rd_data !== 4'd8) begin failed++; $display("FAIL chain_rrat1: got %0d expected 8", rrat_rd_data); end
        step();
        commit_valid = 1'b0;
        #1;
        tests_run++;
        if (free_pd !== 4'd8 || rel_count !== 3'd1) begin failed++; $display("FAIL chain_second_free: got pd=%0d cnt=%0d expected pd=8 cnt=1", free_pd, rel_count); end
        step();
        tests_run++;
        if (free_valid !== 1'b0 || free_pd !== 4'd0) begin failed++; $display("FAIL chain_empty: got v=%0b pd=%0d expected v=0 pd=0", free_valid, free_pd); end
    endtask

    task automatic test_full();
        int exp_seq [5] = '{2, 3, 4, 5, 6};
        free_ready = 1'b0;
        commit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            commit_rd = 3'(2 + i); commit_pd = 4'(10 + i);
            step();
        end
        tests_run++;
        if (rel_count !== 3'd4 || commit_ready !== 1'b0) begin failed++; $display("FAIL full_state: got cnt=%0d rdy=%0b expected cnt=4 rdy=0", rel_count, commit_ready); end
        commit_rd = 3'd6; commit_pd = 4'd14; rrat_rd_addr = 3'd6;
        step(); step();
        tests_run++;
        if (rrat_rd_data !== 4'd6 || rel_count !== 3'd4) begin failed++; $display("FAIL full_held: got rrat6=%0d cnt=%0d expected rrat6=6 cnt=4", rrat_rd_data, rel_count); end
        tests_run++;
        if (free_pd !== 4'd2) begin failed++; $display("FAIL full_head: got %0d expected 2", free_pd); end
        free_ready = 1'b1;
        #1;
        tests_run++;
        if (commit_ready !== 1'b0) begin failed++; $display("FAIL full_ready_no_bypass: got %0b expected 0", commit_ready); end
        step();
        tests_run++;
        if (commit_ready !== 1'b1 || rrat_rd_data !== 4'd6) begin failed++; $display("FAIL full_after_pop: got rdy=%0b rrat6=%0d expected rdy=1 rrat6=6", commit_ready, rrat_rd_data); end
        step();
        commit_valid = 1'b0;
        #1;
        tests_run++;
        if (rrat_rd_data !== 4'd14 || rel_count !== 3'd3) begin failed++; $display("FAIL full_held_accepted: got rrat6=%0d cnt=%0d expected rrat6=14 cnt=3", rrat_rd_data, rel_count); end
        for (int k = 2; k < 5; k++) begin
            tests_run++;
            if (free_pd !== 4'(exp_seq[k])) begin failed++; $display("FAIL full_drain[%0d]: got %0d expected %0d", k, free_pd, exp_seq[k]); end
            step();
        end
        tests_run++;
        if (free_valid !== 1'b0) begin failed++; $display("FAIL full_drained: got %0b expected 0", free_valid); end
    endtask

    task automatic test_simul();
        free_ready = 1'b0;
        commit_valid = 1'b1;
        commit_rd = 3'd3; commit_pd = 4'd0; step();
        commit_rd = 3'd4; commit_pd = 4'd1; step();
        commit_rd = 3'd7; commit_pd = 4'd15; free_ready = 1'b1;
        #1;
        tests_run++;
        if (free_pd !== 4'd11 || rel_count !== 3'd2) begin failed++; $display("FAIL simul_pre: got pd=%0d cnt=%0d expected pd=11 cnt=2", free_pd, rel_count); end
        step();
        commit_valid = 1'b0;
        #1;
        tests_run++;
        if (rel_count !== 3'd2 || free_pd !== 4'd12) begin failed++; $display("FAIL simul_count: got cnt=%0d pd=%0d expected cnt=2 pd=12", rel_count, free_pd); end
        step();
        tests_run++;
        if (free_pd !== 4'd7) begin failed++; $display("FAIL simul_tail: got %0d expected 7", free_pd); end
        step();
    endtask

    task automatic test_noop();
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        free_ready = 1'b0;
        commit_valid = 1'b1; commit_rd = 3'd6; commit_pd = 4'd6; rrat_rd_addr = 3'd6;
        step();
        commit_valid = 1'b0;
        #1;
        tests_run++;
        if (rel_count !== 3'd0 || free_valid !== 1'b0 || rrat_rd_data !== 4'd6) begin failed++; $display("FAIL noop: got cnt=%0d v=%0b rrat6=%0d expected cnt=0 v=0 rrat6=6", rel_count, free_valid, rrat_rd_data); end
    endtask

    task automatic test_en_and_reset();
        free_ready = 1'b0;
        commit_valid = 1'b1;
        commit_rd = 3'd1; commit_pd = 4'd8; step();
        commit_rd = 3'd2; commit_pd = 4'd9; step();
        en = 1'b0; commit_rd = 3'd3; commit_pd = 4'd10; free_ready = 1'b1; rrat_rd_addr = 3'd3;
        #1;
        tests_run++;
        if (commit_ready !== 1'b0) begin failed++; $display("FAIL en_ready: got %0b expected 0", commit_ready); end
        step();
        tests_run++;
        if (rel_count !== 3'd1 || free_pd !== 4'd2 || rrat_rd_data !== 4'd3) begin failed++; $display("FAIL en_drain: got cnt=%0d pd=%0d rrat3=%0d expected cnt=1 pd=2 rrat3=3", rel_count, free_pd, rrat_rd_data); end
        en = 1'b1; free_ready = 1'b0;
        commit_rd = 3'd3; commit_pd = 4'd10; step();
        commit_rd = 3'd4; commit_pd = 4'd11; step();
        commit_valid = 1'b0;
        #1;
        tests_run++;
        if (rel_count !== 3'd3) begin failed++; $display("FAIL pre_reset_count: got %0d expected 3", rel_count); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (rel_count !== 3'd0 || free_valid !== 1'b0 || free_pd !== 4'd0 || commit_ready !== 1'b0) begin failed++; $display("FAIL async_reset: got cnt=%0d v=%0b pd=%0d rdy=%0b expected 0 0 0 0", rel_count, free_valid, free_pd, commit_ready); end
        for (int i = 0; i < 8; i++) begin
            rrat_rd_addr = 3'(i);
            #1;
            tests_run++;
            if (rrat_rd_data !== 4'(i)) begin failed++; $display("FAIL async_reset_rrat[%0d]: got %0d expected %0d", i, rrat_rd_data, i); end
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en           = ($urandom_range(0, 7) != 0);
            commit_valid = $urandom_range(0, 1);
            commit_rd    = 3'($urandom_range(0, 7));
            commit_pd    = 4'($urandom_range(0, 15));
            free_ready   = ($urandom_range(0, 2) == 0);
            rrat_rd_addr = 3'($urandom_range(0, 7));
            #1;
            tests_run++;
            if (commit_ready !== (en && q_m.size() < 4)) begin failed++; $display("FAIL rand_ready[%0d]: got %0b expected %0b", n, commit_ready, en && q_m.size() < 4); end
            tests_run++;
            if (rel_count !== 3'(q_m.size()) || free_valid !== (q_m.size() != 0)) begin failed++; $display("FAIL rand_count[%0d]: got cnt=%0d v=%0b expected cnt=%0d", n, rel_count, free_valid, q_m.size()); end
            tests_run++;
            if (free_pd !== 4'((q_m.size() != 0) ? q_m[0] : 0)) begin failed++; $display("FAIL rand_free_pd[%0d]: got %0d expected %0d", n, free_pd, (q_m.size() != 0) ? q_m[0] : 0); end
            tests_run++;
            if (rrat_rd_data !== 4'(rrat_m[rrat_rd_addr])) begin failed++; $display("FAIL rand_rrat[%0d]: addr=%0d got %0d expected %0d", n, rrat_rd_addr, rrat_rd_data, rrat_m[rrat_rd_addr]); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_chain();
        test_full();
        test_simul();
        test_noop();
        test_en_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
